// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the programmable interrupt controller:
// register offsets, cause codes, claim sentinel and FSM encoding.
package int_ctrl_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    localparam logic [2:0] CAUSE_RAM      = 3'd0;
    localparam logic [2:0] CAUSE_DISK     = 3'd1;
    localparam logic [2:0] CAUSE_VRAM     = 3'd2;
    localparam logic [2:0] CAUSE_KEYBOARD = 3'd3;
    localparam logic [2:0] CAUSE_COUNTER  = 3'd4;
    localparam logic [2:0] CAUSE_SWITCH   = 3'd5;

    localparam logic [31:0] CLAIM_NONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StService
    } state_e;

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for one interrupt source plus a previous-value
// register, giving the synced level and a one-cycle rising-edge pulse.
module int_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= src_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: per-source sync and edge/level capture,
// masking, fixed lowest-index priority and claim/EOI sequencing on Wishbone.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned        N_SRC    = 6,
    parameter logic [N_SRC-1:0]   MASK_RST = {N_SRC{1'b1}},
    parameter logic [N_SRC-1:0]   EDGE_RST = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_int,
    input  logic             STB,
    input  logic             WE,
    input  logic [31:0]      ADDR,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    output logic             ACK,
    output logic             INT,
    output logic [31:0]      CAUSE
);

    localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] src_level;
    logic [N_SRC-1:0] src_rise;

    for (genvar g = 0; g < N_SRC; g++) begin : gen_sync
        int_sync_edge u_sync (
            .clk_i   (clk),
            .rst_i   (rst),
            .src_i   (src_int[g]),
            .level_o (src_level[g]),
            .rise_o  (src_rise[g])
        );
    end

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] clr;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  cause_q, cause_d;
    logic [IdxW-1:0]  svc_q, svc_d;
    logic [IdxW-1:0]  cause_out;
    logic             int_out;

    logic             ack_q;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rdata;

    logic             win_valid;
    logic [IdxW-1:0]  win_idx;
    logic [31:0]      win_word;
    logic [31:0]      cause_word;

    logic             access;
    logic             wr;
    logic             rd;
    logic [1:0]       reg_sel;
    logic             claim_ok;
    logic             claim_hit;
    logic             eoi;

    // Edge-mode bits are latched; level-mode bits follow the synced input.
    assign pending = (pending_q & edge_q) | (src_level & ~edge_q);

    // Scan downwards so the lowest index is the last one written.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i] && mask_q[i]) begin
                win_valid = 1'b1;
                win_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        win_word   = '0;
        win_word[IdxW-1:0] = win_idx;
        cause_word = '0;
        cause_word[IdxW-1:0] = cause_out;
    end

    // Side effects fire only on the cycle ACK goes 0 -> 1.
    assign access    = STB & ~ack_q;
    assign wr        = access & WE;
    assign rd        = access & ~WE;
    assign reg_sel   = ADDR[3:2];
    assign claim_ok  = (state_q == StAssert) && win_valid;
    assign claim_hit = rd && (reg_sel == REG_CLAIM) && claim_ok;
    assign eoi       = wr && (reg_sel == REG_CLAIM) && (state_q == StService);

    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        clr    = '0;
        if (wr) begin
            case (reg_sel)
                REG_PENDING: clr    = DAT_I[N_SRC-1:0];
                REG_MASK:    mask_d = DAT_I[N_SRC-1:0];
                REG_EDGE:    edge_d = DAT_I[N_SRC-1:0];
                default:     ;
            endcase
        end
        if (claim_hit) begin
            clr[win_idx] = 1'b1;
        end
        // A fresh edge wins over any clear in the same cycle.
        pending_d = ((pending_q & ~clr & ~(edge_q ^ edge_d)) | src_rise) & edge_d;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING: rdata[N_SRC-1:0] = pending;
            REG_MASK:    rdata[N_SRC-1:0] = mask_q;
            REG_EDGE:    rdata[N_SRC-1:0] = edge_q;
            default:     rdata = claim_ok ? win_word : CLAIM_NONE;
        endcase
    end

    always_comb begin
        dat_d = dat_q;
        if (access) begin
            dat_d = WE ? '0 : rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        svc_d     = svc_q;
        int_out   = 1'b0;
        cause_out = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StAssert;
                    cause_d = win_idx;
                end
            end
            StAssert: begin
                int_out   = 1'b1;
                cause_out = win_valid ? win_idx : cause_q;
                if (claim_hit) begin
                    state_d = StService;
                    svc_d   = win_idx;
                end else if (!win_valid) begin
                    state_d = StIdle;
                end else begin
                    cause_d = win_idx;
                end
            end
            StService: begin
                cause_out = svc_q;
                if (eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= MASK_RST;
            edge_q    <= EDGE_RST;
            state_q   <= StIdle;
            cause_q   <= '0;
            svc_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            state_q   <= state_d;
            cause_q   <= cause_d;
            svc_q     <= svc_d;
            ack_q     <= STB;
            dat_q     <= dat_d;
        end
    end

    assign ACK   = ack_q;
    assign DAT_O = dat_q;
    assign INT   = int_out;
    assign CAUSE = cause_word;

    logic unused_bits;
    assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I[31:N_SRC]};

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed scenarios followed by random
// bus/source traffic, checked against a behavioural controller model.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  src_int;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        INT;
    logic [31:0] CAUSE;

    int_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .src_int (src_int),
        .STB     (STB),
        .WE      (WE),
        .ADDR    (ADDR),
        .DAT_I   (DAT_I),
        .DAT_O   (DAT_O),
        .ACK     (ACK),
        .INT     (INT),
        .CAUSE   (CAUSE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    int ack_len     = 0;

    typedef struct {
        bit          is_read;
        logic [1:0]  r;
        logic [31:0] exp;
    } txn_t;
    txn_t sb_q[$];

    // Behavioural model: src levels, latched edges, mask, mode, service state.
    logic [5:0] lvl, latch, mask_m, edge_m;
    bit         serving;
    int         in_svc;

    function automatic logic [5:0] m_pend();
        return (latch & edge_m) | (lvl & ~edge_m);
    endfunction

    function automatic int m_win();
        logic [5:0] v;
        v = m_pend() & mask_m;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic string reg_name(input logic [1:0] r);
        case (r)
            2'd0:    return "PENDING";
            2'd1:    return "MASK";
            2'd2:    return "EDGE";
            default: return "CLAIM";
        endcase
    endfunction

    task automatic model_reset();
        lvl     = 6'h00;
        latch   = 6'h00;
        mask_m  = 6'h3F;
        edge_m  = 6'h3F;
        serving = 1'b0;
        in_svc  = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int   w;
        logic exp_int;
        int   exp_cause;
        w         = m_win();
        exp_int   = !serving && (w >= 0);
        exp_cause = serving ? in_svc : (exp_int ? w : 0);
        chk({tag, " INT"}, {31'b0, INT}, {31'b0, exp_int});
        chk({tag, " CAUSE"}, CAUSE, exp_cause);
    endtask

    // Predicts the response, updates the model, then runs the bus cycle.
    task automatic bus(input logic we, input logic [1:0] r, input logic [31:0] d, input int hold);
        txn_t        t;
        logic [31:0] a;
        int          w;
        t.is_read = !we;
        t.r       = r;
        t.exp     = '0;
        w         = m_win();
        if (!we) begin
            case (r)
                2'd0: t.exp = {26'b0, m_pend()};
                2'd1: t.exp = {26'b0, mask_m};
                2'd2: t.exp = {26'b0, edge_m};
                default: begin
                    if (!serving && w >= 0) begin
                        t.exp   = w;
                        serving = 1'b1;
                        in_svc  = w;
                        latch[w] = 1'b0;
                    end else begin
                        t.exp = CLAIM_NONE;
                    end
                end
            endcase
        end else begin
            case (r)
                2'd0: latch = latch & ~d[5:0];
                2'd1: mask_m = d[5:0];
                2'd2: begin
                    latch  = latch & ~(edge_m ^ d[5:0]) & d[5:0];
                    edge_m = d[5:0];
                end
                default: serving = 1'b0;
            endcase
        end
        sb_q.push_back(t);
        a = $urandom;
        a[3:2] = r;
        @(negedge clk);
        STB   = 1'b1;
        WE    = we;
        ADDR  = a;
        DAT_I = d;
        repeat (hold) @(negedge clk);
        STB = 1'b0;
        WE  = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_src(input logic [5:0] v);
        @(negedge clk);
        latch   = latch | (v & ~lvl & edge_m);
        lvl     = v;
        src_int = v;
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_data(input logic [5:0] low);
        logic [31:0] d;
        d = $urandom;
        d[5:0] = low;
        return d;
    endfunction

    // Monitor: pops an expectation when ACK rises, checks DAT_O each ACK cycle.
    initial begin
        txn_t cur;
        bit   cur_ok;
        bit   ack_prev;
        cur_ok   = 1'b0;
        ack_prev = 1'b0;
        cur.is_read = 1'b0;
        cur.r       = 2'd0;
        cur.exp     = '0;
        forever begin
            @(negedge clk);
            if (ACK === 1'b1) begin
                if (!ack_prev) begin
                    ack_len = 0;
                    if (sb_q.size() == 0) begin
                        cur_ok = 1'b0;
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ack: got ACK=1, want no transaction (t=%0t)", $time);
                    end else begin
                        cur    = sb_q.pop_front();
                        cur_ok = 1'b1;
                    end
                end
                ack_len++;
                if (cur_ok && cur.is_read) begin
                    chk({"read ", reg_name(cur.r)}, DAT_O, cur.exp);
                end
            end
            ack_prev = (ACK === 1'b1);
        end
    end

    initial begin
        rst     = 1'b1;
        src_int = '0;
        STB     = 1'b0;
        WE      = 1'b0;
        ADDR    = '0;
        DAT_I   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset ACK", {31'b0, ACK}, 32'd0);
        chk("reset INT", {31'b0, INT}, 32'd0);
        chk("reset CAUSE", CAUSE, 32'd0);
        chk("reset DAT_O", DAT_O, 32'd0);
        rst = 1'b0;

        bus(1'b0, REG_PENDING, '0, 1);
        bus(1'b0, REG_MASK, '0, 1);
        bus(1'b0, REG_EDGE, '0, 1);
        // Claim with nothing pending, strobe held for five cycles.
        bus(1'b0, REG_CLAIM, '0, 5);
        chk("idle claim ACK cycles", ack_len, 5);
        check_status("idle");

        // One-cycle pulse on Switch: pending after 3 clk, INT one clk later.
        @(negedge clk);
        src_int = 6'h20;
        latch   = latch | 6'h20;
        @(negedge clk);
        src_int = 6'h00;
        @(negedge clk);
        chk("latency early INT", {31'b0, INT}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("latency INT", {31'b0, INT}, 32'd1);
        chk("latency CAUSE", CAUSE, {29'b0, CAUSE_SWITCH});
        bus(1'b0, REG_PENDING, '0, 1);
        bus(1'b0, REG_CLAIM, '0, 1);
        check_status("switch claimed");
        bus(1'b1, REG_CLAIM, $urandom, 1);
        check_status("switch eoi");

        // Keyboard and Switch together: Keyboard first, then Switch after EOI.
        set_src(6'h28);
        check_status("kbd+switch");
        bus(1'b0, REG_CLAIM, '0, 1);
        check_status("kbd claimed");
        bus(1'b1, REG_CLAIM, $urandom, 1);
        check_status("after kbd eoi");
        bus(1'b0, REG_CLAIM, '0, 1);
        bus(1'b1, REG_CLAIM, $urandom, 1);
        check_status("after switch eoi");

        // Masking a pending source drops INT; unmasking restores it.
        set_src(6'h00);
        set_src(6'h20);
        bus(1'b1, REG_MASK, rnd_data(6'h1F), 1);
        check_status("masked");
        bus(1'b1, REG_MASK, rnd_data(6'h3F), 1);
        check_status("unmasked");

        // Held claim in ASSERT must claim once only.
        bus(1'b0, REG_CLAIM, '0, 5);
        chk("held claim ACK cycles", ack_len, 5);
        bus(1'b0, REG_CLAIM, '0, 1);
        bus(1'b0, REG_PENDING, '0, 1);
        bus(1'b1, REG_CLAIM, $urandom, 1);
        check_status("after held claim");

        // Level mode on Disk: W1C has no lasting effect, release clears.
        set_src(6'h00);
        bus(1'b1, REG_EDGE, rnd_data(6'h00), 1);
        set_src(6'h02);
        check_status("level disk");
        bus(1'b1, REG_PENDING, rnd_data(6'h02), 1);
        bus(1'b0, REG_PENDING, '0, 1);
        set_src(6'h00);
        check_status("level released");
        bus(1'b0, REG_PENDING, '0, 1);
        bus(1'b1, REG_EDGE, rnd_data(6'h3F), 1);

        // Random traffic against the model.
        for (int n = 0; n < 120; n++) begin
            int op;
            int hold;
            op   = $urandom_range(0, 7);
            hold = $urandom_range(1, 3);
            case (op)
                0: set_src(6'($urandom));
                1: bus(1'b1, REG_MASK, $urandom, hold);
                2: bus(1'b1, REG_EDGE, $urandom, hold);
                3: bus(1'b1, REG_PENDING, $urandom, hold);
                4: bus(1'b0, 2'($urandom_range(0, 2)), '0, hold);
                5, 6: bus(1'b0, REG_CLAIM, '0, hold);
                default: bus(1'b1, REG_CLAIM, $urandom, hold);
            endcase
            repeat (2) @(negedge clk);
            check_status("random");
        end

        // Reset in SERVICE with a strobe pending aborts everything.
        bus(1'b1, REG_MASK, rnd_data(6'h3F), 1);
        bus(1'b1, REG_EDGE, rnd_data(6'h3F), 1);
        bus(1'b1, REG_CLAIM, $urandom, 1);
        set_src(6'h00);
        bus(1'b1, REG_PENDING, rnd_data(6'h3F), 1);
        set_src(6'h08);
        bus(1'b0, REG_CLAIM, '0, 1);
        check_status("pre-reset service");
        set_src(6'h00);
        @(negedge clk);
        STB  = 1'b1;
        WE   = 1'b0;
        ADDR = {28'b0, REG_MASK, 2'b00};
        #2 rst = 1'b1;
        #1;
        chk("mid-reset ACK", {31'b0, ACK}, 32'd0);
        chk("mid-reset INT", {31'b0, INT}, 32'd0);
        chk("mid-reset CAUSE", CAUSE, 32'd0);
        chk("mid-reset DAT_O", DAT_O, 32'd0);
        repeat (2) @(negedge clk);
        chk("held reset ACK", {31'b0, ACK}, 32'd0);
        STB = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post-reset ACK", {31'b0, ACK}, 32'd0);
        bus(1'b0, REG_MASK, '0, 1);
        check_status("post-reset");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
